// File: rtl/reg_file_param.sv
// reg_file_param: parametrised two-read / one-write register file.
// Registered read ports with optional same-edge write bypass, an optional
// hardwired-zero register 0, and a sequential clear engine that walks every
// address once while BUSY is high. Writes arriving during a clear are
// discarded and flagged on WDROP for one cycle.
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INaddr,
  input  logic              WE,
  input  logic [ADDR_W-1:0] OUT1addr,
  input  logic [ADDR_W-1:0] OUT2addr,
  input  logic              CLR,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              BUSY,
  output logic              WDROP
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ADDR_W-1:0]  cnt_r;
  logic [ADDR_W-1:0]  cnt_nxt_s;
  logic [WIDTH-1:0]   regs_r [DEPTH];
  logic [WIDTH-1:0]   out1_r;
  logic [WIDTH-1:0]   out2_r;
  logic [WIDTH-1:0]   out1_nxt_s;
  logic [WIDTH-1:0]   out2_nxt_s;
  logic               busy_r;
  logic               wdrop_r;
  logic               wdrop_nxt_s;
  logic               wr_acc_s;

  // Clear-engine next state: IDLE starts a sweep on CLR, CLEAR walks every address once.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (CLR) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_CLEAR: begin
        // CLR is deliberately not looked at here: a request during a sweep is dropped.
        cnt_nxt_s = cnt_r + ADDR_W'(1);
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Write acceptance: only in IDLE; register 0 silently ignores writes when hardwired to zero.
  always_comb begin
    wr_acc_s    = 1'b0;
    wdrop_nxt_s = 1'b0;
    if (state_r == ST_IDLE) begin
      wr_acc_s    = WE && !(ZERO_REG && (INaddr == {ADDR_W{1'b0}}));
      wdrop_nxt_s = 1'b0;
    end else begin
      wr_acc_s    = 1'b0;
      wdrop_nxt_s = WE;
    end
  end

  // Read-port data selection: bypass of an accepted write, then zero register, then array.
  always_comb begin
    out1_nxt_s = regs_r[OUT1addr];
    out2_nxt_s = regs_r[OUT2addr];
    if (BYPASS && wr_acc_s && (INaddr == OUT1addr)) begin
      out1_nxt_s = IN;
    end else if (ZERO_REG && (OUT1addr == {ADDR_W{1'b0}})) begin
      out1_nxt_s = {WIDTH{1'b0}};
    end else begin
      out1_nxt_s = regs_r[OUT1addr];
    end
    if (BYPASS && wr_acc_s && (INaddr == OUT2addr)) begin
      out2_nxt_s = IN;
    end else if (ZERO_REG && (OUT2addr == {ADDR_W{1'b0}})) begin
      out2_nxt_s = {WIDTH{1'b0}};
    end else begin
      out2_nxt_s = regs_r[OUT2addr];
    end
  end

  // Register array: clear-engine writes take priority, otherwise accepted datapath writes.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (state_r == ST_CLEAR) begin
      regs_r[cnt_r] <= {WIDTH{1'b0}};
    end else if (wr_acc_s) begin
      regs_r[INaddr] <= IN;
    end
  end

  // Control and output registers: FSM state, sweep counter, BUSY, WDROP and read data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      wdrop_r <= 1'b0;
      out1_r  <= {WIDTH{1'b0}};
      out2_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
      wdrop_r <= wdrop_nxt_s;
      out1_r  <= out1_nxt_s;
      out2_r  <= out2_nxt_s;
    end
  end

  assign OUT1  = out1_r;
  assign OUT2  = out2_r;
  assign BUSY  = busy_r;
  assign WDROP = wdrop_r;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: two instances share one stimulus stream.
//   dut_a: BYPASS=0, ZERO_REG=0     dut_b: BYPASS=1, ZERO_REG=1
// A behavioural model predicts every output at drive time and queues it;
// the queue is popped and compared after each rising edge. Directed
// constant checks cover the specific scenarios of interest.
module tb_reg_file_param;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INaddr;
  logic       WE;
  logic [2:0] OUT1addr;
  logic [2:0] OUT2addr;
  logic       CLR;

  logic [7:0] a_out1, a_out2, b_out1, b_out2;
  logic       a_busy, a_wdrop, b_busy, b_wdrop;

  always #5 CLK = ~CLK;

  reg_file_param #(.WIDTH(8), .ADDR_W(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_a (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WE(WE),
    .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .CLR(CLR),
    .OUT1(a_out1), .OUT2(a_out2), .BUSY(a_busy), .WDROP(a_wdrop)
  );

  reg_file_param #(.WIDTH(8), .ADDR_W(3), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WE(WE),
    .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .CLR(CLR),
    .OUT1(b_out1), .OUT2(b_out2), .BUSY(b_busy), .WDROP(b_wdrop)
  );

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       abusy;
    logic       awdrop;
    logic       bbusy;
    logic       bwdrop;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   busy_hi = 0;

  // Reference model, index 0 = dut_a configuration, index 1 = dut_b configuration
  logic [7:0] m_reg  [2][8];
  logic       m_busy [2];
  logic [2:0] m_cnt  [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 8; r++) m_reg[c][r] = 8'h00;
      m_busy[c] = 1'b0;
      m_cnt[c]  = 3'd0;
    end
  endtask

  // Drive one cycle of stimulus (called at negedge), predict, then check after the edge.
  task automatic step(input logic we, input logic [2:0] ia, input logic [7:0] din,
                      input logic [2:0] a1, input logic [2:0] a2, input logic clr);
    logic [7:0] e1 [2];
    logic [7:0] e2 [2];
    logic       eb [2];
    logic       ew [2];
    exp_t       e;
    exp_t       got;
    for (int c = 0; c < 2; c++) begin
      logic zr, byp, acc, drop;
      zr   = (c == 1);
      byp  = (c == 1);
      acc  = !m_busy[c] && we && !(zr && (ia == 3'd0));
      drop = m_busy[c] && we;
      if (byp && acc && (ia == a1))  e1[c] = din;
      else if (zr && (a1 == 3'd0))   e1[c] = 8'h00;
      else                           e1[c] = m_reg[c][a1];
      if (byp && acc && (ia == a2))  e2[c] = din;
      else if (zr && (a2 == 3'd0))   e2[c] = 8'h00;
      else                           e2[c] = m_reg[c][a2];
      if (m_busy[c]) begin
        m_reg[c][m_cnt[c]] = 8'h00;
        if (m_cnt[c] == 3'd7) m_busy[c] = 1'b0;
        m_cnt[c] = m_cnt[c] + 3'd1;
      end else begin
        if (acc) m_reg[c][ia] = din;
        if (clr) begin
          m_busy[c] = 1'b1;
          m_cnt[c]  = 3'd0;
        end
      end
      eb[c] = m_busy[c];
      ew[c] = drop;
    end
    e.a1 = e1[0]; e.a2 = e2[0]; e.b1 = e1[1]; e.b2 = e2[1];
    e.abusy = eb[0]; e.awdrop = ew[0]; e.bbusy = eb[1]; e.bwdrop = ew[1];
    sb_q.push_back(e);

    WE = we; INaddr = ia; IN = din; OUT1addr = a1; OUT2addr = a2; CLR = clr;
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 8'd0, 8'd1);
    end else begin
      got = sb_q.pop_front();
      chk("a_out1", a_out1, got.a1);
      chk("a_out2", a_out2, got.a2);
      chk("b_out1", b_out1, got.b1);
      chk("b_out2", b_out2, got.b2);
      chk("a_busy", 8'(a_busy), 8'(got.abusy));
      chk("a_wdrop", 8'(a_wdrop), 8'(got.awdrop));
      chk("b_busy", 8'(b_busy), 8'(got.bbusy));
      chk("b_wdrop", 8'(b_wdrop), 8'(got.bwdrop));
    end
    if (a_busy) busy_hi++;
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] v;
    RESET = 1'b0; IN = 8'h00; INaddr = 3'd0; WE = 1'b0;
    OUT1addr = 3'd0; OUT2addr = 3'd0; CLR = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_a_out1", a_out1, 8'h00);
    chk("rst_a_out2", a_out2, 8'h00);
    chk("rst_a_busy", 8'(a_busy), 8'h00);
    chk("rst_a_wdrop", 8'(a_wdrop), 8'h00);
    chk("rst_b_out1", b_out1, 8'h00);
    chk("rst_b_busy", 8'(b_busy), 8'h00);
    @(negedge CLK);
    RESET = 1'b1;

    // Basic write/read without bypass
    step(1'b1, 3'd3, 8'hCE, 3'd3, 3'd0, 1'b0);
    chk("basic_e1_out1", a_out1, 8'h00);
    step(1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0);
    chk("basic_e2_out1", a_out1, 8'hCE);
    chk("basic_e2_out2", a_out2, 8'h00);

    // Same-edge bypass on both ports
    step(1'b1, 3'd5, 8'hA5, 3'd5, 3'd5, 1'b0);
    chk("byp_out1", b_out1, 8'hA5);
    chk("byp_out2", b_out2, 8'hA5);
    chk("nobyp_out1", a_out1, 8'h00);

    // Hardwired zero register
    step(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 1'b0);
    chk("zr_wdrop", 8'(b_wdrop), 8'h00);
    step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0);
    chk("zr_read0", b_out1, 8'h00);
    chk("nozr_read0", a_out1, 8'hFF);

    // Preload 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      v = 8'h11 * 8'(i + 1);
      step(1'b1, 3'(i), v, 3'(i), 3'd0, 1'b0);
    end

    // Clear sweep: E0 samples CLR, E1..E8 clear addresses 0..7
    busy_hi = 0;
    step(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b1);
    chk("clr_e0_busy", 8'(a_busy), 8'h01);
    for (int k = 1; k <= 8; k++) begin
      step(k == 3, 3'd2, 8'h5A, 3'(k - 1), (k == 1) ? 3'd0 : 3'(k - 2), k == 2);
      if (k == 3) chk("clr_wdrop_hi", 8'(a_wdrop), 8'h01);
      if (k == 4) chk("clr_wdrop_lo", 8'(a_wdrop), 8'h00);
      if (k == 8) chk("clr_e8_rd7", a_out1, 8'h88);
    end
    chk("clr_busy_cycles", 8'(busy_hi), 8'd8);
    chk("clr_busy_done", 8'(a_busy), 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0);
      chk("post_clr_rd", a_out1, 8'h00);
    end
    chk("post_clr_still_idle", 8'(a_busy), 8'h00);
    step(1'b1, 3'd2, 8'h3C, 3'd2, 3'd2, 1'b0);
    chk("post_clr_wr_byp", b_out1, 8'h3C);

    // Simultaneous write+clear, then asynchronous reset mid-sweep
    step(1'b1, 3'd6, 8'hC3, 3'd0, 3'd0, 1'b0);
    step(1'b1, 3'd4, 8'h77, 3'd6, 3'd4, 1'b1);
    chk("wrclr_b_byp", b_out2, 8'h77);
    for (int k = 1; k <= 4; k++) begin
      step(k == 4, 3'd5, 8'h99, 3'd6, 3'd4, 1'b0);
    end
    chk("pre_rst_wdrop", 8'(a_wdrop), 8'h01);
    chk("pre_rst_out1", a_out1, 8'hC3);
    chk("pre_rst_out2", a_out2, 8'h77);
    RESET = 1'b0;
    #1;
    chk("arst_a_out1", a_out1, 8'h00);
    chk("arst_a_out2", a_out2, 8'h00);
    chk("arst_a_busy", 8'(a_busy), 8'h00);
    chk("arst_a_wdrop", 8'(a_wdrop), 8'h00);
    chk("arst_b_out2", b_out2, 8'h00);
    chk("arst_b_busy", 8'(b_busy), 8'h00);
    model_reset();
    // Writes must not land while reset is held
    WE = 1'b1; INaddr = 3'd6; IN = 8'h99; CLR = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
      chk("arst_post_rd", a_out1, 8'h00);
    end
    chk("sb_drained", 8'(sb_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-port register file, the next generation of the 8x8 two-read/one-write register file. It is used by the datapath to supply two ALU operands per cycle and to accept one result per cycle. Width and depth are configurable. It adds an explicit write enable, single-edge timing, optional same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a multi-cycle sequential clear engine with a busy indication.

## Interface
- WIDTH, 8, data width of each register and of IN/OUT1/OUT2
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1: a read of the address written in the same cycle returns the new data; 0: it returns the old data
- ZERO_REG, 0, 1: register 0 always reads 0 and writes to it are discarded

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  asynchronous, active-low reset
- IN  input  WIDTH  write data
- INaddr  input  ADDR_W  write address
- WE  input  1  write enable
- OUT1addr  input  ADDR_W  read port 1 address
- OUT2addr  input  ADDR_W  read port 2 address
- CLR  input  1  request a sequential clear of all registers
- OUT1  output  WIDTH  registered read data, port 1
- OUT2  output  WIDTH  registered read data, port 2
- BUSY  output  1  clear sequence in progress
- WDROP  output  1  one-cycle pulse: a write was discarded because BUSY was high

## Operation
- Reset (RESET=0, asynchronous): all registers, OUT1, OUT2 and the clear counter go to 0. BUSY=0, WDROP=0, FSM=IDLE. An asserted reset aborts any clear in progress.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on a rising edge with CLR=1. The counter loads 0.
  - CLEAR: each edge writes 0 to reg[cnt], then cnt increments.
  - CLEAR -> IDLE on the edge that clears address DEPTH-1. The counter wraps to 0.
  - CLR is ignored while in CLEAR; it is not queued.
- BUSY = (state == CLEAR), driven from a register.
- Write, on a rising edge:
  - In IDLE with WE=1, reg[INaddr] <= IN.
  - If ZERO_REG=1 and INaddr=0, the write is discarded silently, with no WDROP.
- Write while busy: in CLEAR with WE=1, the write is discarded and WDROP is set to 1 for exactly one cycle.
- Simultaneous CLR=1 and WE=1 in IDLE: the write is performed at that edge, and the clear starts with the same edge. The written value is cleared later by the sequence.
- Reads happen on every rising edge, independent of WE and BUSY:
  - OUT1 <= reg[OUT1addr] and OUT2 <= reg[OUT2addr], using pre-edge contents.
- Bypass (BYPASS=1): if a write is accepted at this edge and INaddr equals a read address, that port loads IN.
  - Bypass does not apply to discarded writes or to clear-engine writes.
- Zero register (ZERO_REG=1): a read of address 0 always loads 0.
- Both read ports may address the same register, and may address the write address, in the same cycle.
- No arithmetic beyond the counter. The counter is ADDR_W bits with natural wrap.

## Timing
- Read latency: 1 cycle. OUT1/OUT2 are valid after the edge that sampled the addresses.
- Write-to-read:
  - With BYPASS=1, data written at edge N is visible on OUTx after edge N when addressed at N.
  - With BYPASS=0, it is visible after edge N+1.
- Clear sequence:
  - Edge E0 samples CLR; BUSY=1 after E0.
  - Edges E1..E_DEPTH clear addresses 0..DEPTH-1.
  - BUSY=0 after E_DEPTH, so BUSY is high for exactly DEPTH cycles.
  - A new write is accepted at E_DEPTH+1.
  - A read at edge Ek (1<=k<=DEPTH) of address k-1 returns its pre-clear value. A read of address k-1 at edge Ek+1 or later returns 0.
- WDROP goes high after the edge where the write was discarded and low after the next edge, unless another write is discarded.
- RESET takes effect asynchronously and releases synchronously to the next rising edge. No writes are accepted while RESET=0.

## Test plan
- Basic write/read, WIDTH=8, ADDR_W=3, BYPASS=0:
  - WE=1, INaddr=3, IN=0xCE at edge 1.
  - OUT1addr=3 at edge 1 -> OUT1=0x00.
  - At edge 2 -> OUT1=0xCE, OUT2 (addr 0) = 0x00.
- Bypass, BYPASS=1: WE=1, INaddr=5, IN=0xA5 and OUT1addr=OUT2addr=5 at the same edge -> OUT1=OUT2=0xA5 after that edge.
- Zero register, ZERO_REG=1:
  - Write 0xFF to address 0 -> subsequent read of address 0 gives 0x00.
  - WDROP stays 0.
- Clear:
  - Preload all 8 registers with 0x11..0x88, pulse CLR -> BUSY high for exactly 8 cycles.
  - Reads afterwards all give 0x00.
  - A read of addr 7 at E8 gives 0x88.
- Write during clear: WE=1, INaddr=2, IN=0x5A at E3 of the clear -> WDROP=1 for one cycle; reg 2 reads 0x00 after the clear; a second CLR during BUSY has no effect.
- Asynchronous reset: assert RESET=0 mid-clear (at E4) between clock edges -> OUT1, OUT2, BUSY and WDROP go to 0 immediately, and all registers read 0x00 after release, including those written before the clear started.
